// File: rtl/vid_mem_pkg.sv
// Shared definitions for the video-to-memory write path: scheduler states,
// default geometry and the width helper used to size length/count fields.
package vid_mem_pkg;

   localparam int DEF_BURST_LEN = 16;
   localparam int DEF_ADDR_W    = 20;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } wr_state_e;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/frame_wr_scheduler_if.sv
// Memory-controller write port: one request/ack handshake per burst followed
// by an unthrottled run of data beats.
interface frame_wr_scheduler_if
   import vid_mem_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = clog2(DEF_BURST_LEN) + 1
);

   logic              mem_req;
   logic              mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [LEN_W-1:0]  mem_len;
   logic              mem_wvalid;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      output mem_req, mem_addr, mem_len, mem_wvalid, mem_wdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req, mem_addr, mem_len, mem_wvalid, mem_wdata,
      output mem_ack
   );

endinterface

// File: rtl/frame_wr_scheduler_pix_fifo.sv
// Pixel buffer between the timing source and the burst engine; read data is
// registered so a pop at edge t presents the word right after edge t.
module pix_fifo
   import vid_mem_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 64
)(
   input  logic                    clk,
   input  logic                    rstb,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_W-1:0]       din,
   output logic [DATA_W-1:0]       dout,
   output logic [clog2(DEPTH):0]   count,
   output logic                    full,
   output logic                    empty
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              push_ok_s;
   logic              pop_ok_s;

   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == {CNT_W{1'b0}});
   assign count     = count_r;
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Storage array write port
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers, occupancy and registered read data
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         dout     <= {DATA_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            dout     <= mem_r[rd_ptr_r];
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/frame_wr_scheduler.sv
// Packs active pixels into fixed-length write bursts and ping-pongs between two
// frame buffers so a reader can consume the previous frame.
module frame_wr_scheduler
   import vid_mem_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter int                ADDR_W     = DEF_ADDR_W,
   parameter int                BURST_LEN  = DEF_BURST_LEN,
   parameter int                FIFO_DEPTH = 64,
   parameter logic [ADDR_W-1:0] BASE0      = ADDR_W'(32'h0000_0000),
   parameter logic [ADDR_W-1:0] BASE1      = ADDR_W'(32'h0008_0000)
)(
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 hav,
   input  logic                 vav,
   input  logic [DATA_W-1:0]    pix_data,
   frame_wr_scheduler_if.master mem,
   output logic                 buf_sel,
   output logic                 frame_done,
   output logic                 overflow
);

   localparam int               LEN_W       = clog2(BURST_LEN) + 1;
   localparam int               CNT_W       = clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] BURST_CNT   = CNT_W'(BURST_LEN);
   localparam logic [LEN_W-1:0] BURST_LEN_V = LEN_W'(BURST_LEN);

   wr_state_e         state_r;
   logic              vav_r;
   logic              pending_end_r;
   logic [ADDR_W-1:0] offset_r;
   logic [LEN_W-1:0]  beats_left_r;

   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;
   logic              vav_fall_s;
   logic              full_burst_s;
   logic              burst_ready_s;
   logic [CNT_W-1:0]  count_s;
   logic [LEN_W-1:0]  next_len_s;
   logic [DATA_W-1:0] wdata_s;

   // Once the frame end is seen, the source is frozen out until hand-over.
   assign push_s        = hav & vav & ~full_s & ~pending_end_r;
   assign vav_fall_s    = vav_r & ~vav;
   assign full_burst_s  = (count_s >= BURST_CNT);
   assign burst_ready_s = full_burst_s | (pending_end_r & ~empty_s);
   assign next_len_s    = full_burst_s ? BURST_LEN_V : count_s[LEN_W-1:0];
   assign mem.mem_wdata = wdata_s;

   // FIFO read strobe: first word on ack, remaining words during DATA
   always_comb begin
      pop_s = 1'b0;
      case (state_r)
         ST_REQ:  pop_s = mem.mem_ack;
         ST_DATA: pop_s = (beats_left_r != {LEN_W{1'b0}});
         default: pop_s = 1'b0;
      endcase
   end

   pix_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_pix_fifo (
      .clk   (clk),
      .rstb  (rstb),
      .push  (push_s),
      .pop   (pop_s),
      .din   (pix_data),
      .dout  (wdata_s),
      .count (count_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Frame-end edge history and sticky dropped-pixel flag
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         vav_r    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         vav_r <= vav;
         if (hav & vav & ~push_s) begin
            overflow <= 1'b1;
         end
      end
   end

   // Burst sequencing: request, data beats, frame hand-over
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_r        <= ST_IDLE;
         pending_end_r  <= 1'b0;
         offset_r       <= {ADDR_W{1'b0}};
         beats_left_r   <= {LEN_W{1'b0}};
         mem.mem_req    <= 1'b0;
         mem.mem_addr   <= {ADDR_W{1'b0}};
         mem.mem_len    <= {LEN_W{1'b0}};
         mem.mem_wvalid <= 1'b0;
         buf_sel        <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (vav_fall_s) begin
            pending_end_r <= 1'b1;
         end
         case (state_r)
            ST_IDLE: begin
               // A full burst always wins over closing the frame.
               if (burst_ready_s) begin
                  state_r      <= ST_REQ;
                  mem.mem_req  <= 1'b1;
                  mem.mem_addr <= (buf_sel ? BASE1 : BASE0) + offset_r;
                  mem.mem_len  <= next_len_s;
               end else if (pending_end_r) begin
                  state_r       <= ST_DONE;
                  frame_done    <= 1'b1;
                  buf_sel       <= ~buf_sel;
                  offset_r      <= {ADDR_W{1'b0}};
                  pending_end_r <= 1'b0;
               end
            end
            ST_REQ: begin
               if (mem.mem_ack) begin
                  state_r        <= ST_DATA;
                  mem.mem_req    <= 1'b0;
                  mem.mem_wvalid <= 1'b1;
                  beats_left_r   <= mem.mem_len - LEN_W'(1);
               end
            end
            ST_DATA: begin
               if (beats_left_r == {LEN_W{1'b0}}) begin
                  state_r        <= ST_IDLE;
                  mem.mem_wvalid <= 1'b0;
                  offset_r       <= offset_r + ADDR_W'(mem.mem_len);
               end else begin
                  beats_left_r <= beats_left_r - LEN_W'(1);
               end
            end
            ST_DONE: state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_wr_scheduler.sv
// Scoreboarded bench for frame_wr_scheduler: frame scenarios from a table plus
// hand-written sequences for mid-burst reset and an empty frame end.
module tb_frame_wr_scheduler;
   import vid_mem_pkg::*;

   localparam int          BL = 16;
   localparam logic [19:0] B0 = 20'h0_0000;
   localparam logic [19:0] B1 = 20'h8_0000;

   typedef struct {
      logic [19:0] addr;
      logic [4:0]  len;
   } burst_t;

   typedef struct {
      int   lines;
      int   ppl;
      int   cap;
      bit   block_ack;
      int   exp_bursts;
      logic exp_buf_sel;
      logic exp_ovf;
   } vec_t;

   logic       clk = 1'b0;
   logic       rstb = 1'b0;
   logic       hav = 1'b0;
   logic       vav = 1'b0;
   logic [7:0] pix_data = 8'h00;
   logic       buf_sel;
   logic       frame_done;
   logic       overflow;

   frame_wr_scheduler_if #(.DATA_W(8), .ADDR_W(20), .LEN_W(5)) mem_bus ();

   frame_wr_scheduler dut (
      .clk        (clk),
      .rstb       (rstb),
      .hav        (hav),
      .vav        (vav),
      .pix_data   (pix_data),
      .mem        (mem_bus),
      .buf_sel    (buf_sel),
      .frame_done (frame_done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_data_q[$];
   burst_t     exp_burst_q[$];
   int         n_req = 0;
   int         n_done = 0;
   int         exp_done = 0;
   int         beat_idx = 0;
   logic       prev_req = 1'b0;
   burst_t     cur;
   int         ack_delay = 2;
   bit         ack_block = 1'b0;
   int         req_age = 0;
   bit         m_buf = 1'b0;
   logic [19:0] m_off = 20'h0;
   int         frame_pix = 0;
   logic [7:0] pix_val = 8'h00;
   vec_t       vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Output monitor: checks every request and beat against the scoreboard
   initial begin
      cur.addr = 20'h0;
      cur.len  = 5'd0;
      forever begin
         @(negedge clk);
         if (rstb) begin
            if (mem_bus.mem_req && !prev_req) begin
               n_req++;
               beat_idx = 0;
               chk("req_expected", 32'(exp_burst_q.size() != 0), 32'd1);
               if (exp_burst_q.size() != 0) begin
                  cur = exp_burst_q.pop_front();
                  chk("req_addr", 32'(mem_bus.mem_addr), 32'(cur.addr));
                  chk("req_len", 32'(mem_bus.mem_len), 32'(cur.len));
               end else begin
                  cur.addr = mem_bus.mem_addr;
                  cur.len  = mem_bus.mem_len;
               end
            end else if (mem_bus.mem_req) begin
               chk("addr_stable", 32'(mem_bus.mem_addr), 32'(cur.addr));
               chk("len_stable", 32'(mem_bus.mem_len), 32'(cur.len));
            end
            if (mem_bus.mem_wvalid) begin
               beat_idx++;
               chk("beat_within_len", 32'(beat_idx <= int'(cur.len)), 32'd1);
               chk("data_expected", 32'(exp_data_q.size() != 0), 32'd1);
               if (exp_data_q.size() != 0) begin
                  chk("wdata", 32'(mem_bus.mem_wdata), 32'(exp_data_q.pop_front()));
               end
            end
            if (frame_done) begin
               n_done++;
            end
            prev_req = mem_bus.mem_req;
         end else begin
            prev_req = 1'b0;
         end
      end
   end

   // Memory controller model: acks a request after ack_delay cycles
   initial begin
      mem_bus.mem_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstb || mem_bus.mem_ack) begin
            mem_bus.mem_ack = 1'b0;
            req_age = 0;
         end else if (mem_bus.mem_req && !ack_block) begin
            if (req_age >= ack_delay) mem_bus.mem_ack = 1'b1;
            else req_age++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic accept_pixel(input logic [7:0] v);
      burst_t b;
      exp_data_q.push_back(v);
      frame_pix++;
      if (frame_pix % BL == 0) begin
         b.addr = (m_buf ? B1 : B0) + m_off;
         b.len  = 5'd16;
         exp_burst_q.push_back(b);
         m_off = m_off + 20'd16;
      end
   endtask

   task automatic end_frame();
      burst_t b;
      if (frame_pix % BL != 0) begin
         b.addr = (m_buf ? B1 : B0) + m_off;
         b.len  = 5'(frame_pix % BL);
         exp_burst_q.push_back(b);
      end
      vav = 1'b0;
      m_buf = ~m_buf;
      m_off = 20'h0;
      frame_pix = 0;
      exp_done++;
   endtask

   task automatic send_frame(input int lines, input int ppl, input int cap, input bit close);
      int driven;
      driven = 0;
      @(negedge clk);
      vav = 1'b1;
      repeat (2) @(negedge clk);
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < ppl; p++) begin
            hav = 1'b1;
            pix_data = pix_val;
            if (driven < cap) accept_pixel(pix_val);
            driven++;
            pix_val = pix_val + 8'd1;
            @(negedge clk);
         end
         hav = 1'b0;
         repeat (4) @(negedge clk);
      end
      if (close) end_frame();
   endtask

   task automatic wait_quiet();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         #2;
         ok = (exp_data_q.size() == 0) && (exp_burst_q.size() == 0) &&
              !mem_bus.mem_req && !mem_bus.mem_wvalid && (n_done == exp_done);
      end
      chk("quiet_before_timeout", 32'(ok), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_mem_req"}, 32'(mem_bus.mem_req), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_bus.mem_addr), 32'd0);
      chk({tag, "_mem_len"}, 32'(mem_bus.mem_len), 32'd0);
      chk({tag, "_mem_wvalid"}, 32'(mem_bus.mem_wvalid), 32'd0);
      chk({tag, "_mem_wdata"}, 32'(mem_bus.mem_wdata), 32'd0);
      chk({tag, "_buf_sel"}, 32'(buf_sel), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
   endtask

   initial begin
      int base_req;
      int base_done;
      bit hit;

      vecs[0] = '{1, 48, 1000, 1'b0, 3, 1'b1, 1'b0};
      vecs[1] = '{3, 20, 1000, 1'b0, 4, 1'b0, 1'b0};
      vecs[2] = '{3, 20, 1000, 1'b0, 4, 1'b1, 1'b0};
      vecs[3] = '{1, 80, 64,   1'b1, 4, 1'b0, 1'b1};

      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rstb = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven frame scenarios
      for (int r = 0; r < 4; r++) begin
         base_req  = n_req;
         base_done = n_done;
         ack_block = vecs[r].block_ack;
         send_frame(vecs[r].lines, vecs[r].ppl, vecs[r].cap, 1'b1);
         if (vecs[r].block_ack) begin
            repeat (120) @(negedge clk);
            #1;
            chk("ovf_while_blocked", 32'(overflow), 32'd1);
            chk("req_held_while_blocked", 32'(mem_bus.mem_req), 32'd1);
            ack_block = 1'b0;
         end
         wait_quiet();
         chk($sformatf("row%0d_bursts", r), 32'(n_req - base_req), 32'(vecs[r].exp_bursts));
         chk($sformatf("row%0d_done", r), 32'(n_done - base_done), 32'd1);
         chk($sformatf("row%0d_buf_sel", r), 32'(buf_sel), 32'(vecs[r].exp_buf_sel));
         chk($sformatf("row%0d_overflow", r), 32'(overflow), 32'(vecs[r].exp_ovf));
      end

      // Reset asserted during the fifth data beat
      send_frame(1, 16, 1000, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 60 && !hit; i++) begin
         #2;
         if (mem_bus.mem_wvalid && beat_idx == 5) hit = 1'b1;
         else @(negedge clk);
      end
      chk("reached_beat5", 32'(hit), 32'd1);
      rstb = 1'b0;
      hav = 1'b0;
      vav = 1'b0;
      #1;
      check_reset_outputs("midburst_reset");
      exp_data_q.delete();
      exp_burst_q.delete();
      m_buf = 1'b0;
      m_off = 20'h0;
      frame_pix = 0;
      beat_idx = 0;
      repeat (3) @(negedge clk);
      rstb = 1'b1;
      base_req  = n_req;
      base_done = n_done;
      send_frame(1, 20, 1000, 1'b1);
      wait_quiet();
      chk("post_reset_bursts", 32'(n_req - base_req), 32'd2);
      chk("post_reset_done", 32'(n_done - base_done), 32'd1);
      chk("post_reset_buf_sel", 32'(buf_sel), 32'd1);
      chk("post_reset_overflow", 32'(overflow), 32'd0);

      // Frame end with an empty FIFO
      @(negedge clk);
      vav = 1'b1;
      repeat (3) @(negedge clk);
      base_req = n_req;
      end_frame();
      @(negedge clk);
      #1;
      chk("empty_end_done_c1", 32'(frame_done), 32'd0);
      @(negedge clk);
      #1;
      chk("empty_end_done_c2", 32'(frame_done), 32'd1);
      @(negedge clk);
      #1;
      chk("empty_end_done_c3", 32'(frame_done), 32'd0);
      chk("empty_end_no_req", 32'(n_req - base_req), 32'd0);
      chk("empty_end_buf_sel", 32'(buf_sel), 32'd0);
      chk("empty_end_done_total", 32'(n_done), 32'(exp_done));

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
